// File: rtl/debounce_pkg.sv
// Package for the push-button debouncer.
// Holds the FSM state encodings and the default debounce parameters
// shared by debounce_oneshot and anything that instantiates it.
package debounce_pkg;

  // Default number of consecutive equal samples needed to change level.
  localparam int STABLE_CNT_DEF = 4;
  // Default width of the stable-sample counter (2**CNT_W > STABLE_CNT).
  localparam int CNT_W_DEF      = 4;

  typedef enum logic [1:0] {
    IDLE         = 2'b00,
    PRESS_WAIT   = 2'b01,
    PRESSED      = 2'b10,
    RELEASE_WAIT = 2'b11
  } state_e;

endpackage

// File: rtl/debounce_oneshot_sync.sv
// sync_2ff: single-bit two-flop synchronizer for an asynchronous level.
// Ports:
//   clk   - destination clock
//   reset - synchronous, active-low reset (clears both flops)
//   d     - asynchronous input level
//   q     - level synchronized to clk (two clk cycles of latency)
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/debounce_oneshot.sv
// debounce_oneshot: push-button debouncer with press/release one-shots.
// The button is sampled once per rising edge of the slow 500 Hz square
// wave (clk_slow, treated as data). A level change is accepted only after
// STABLE_CNT consecutive samples agree; the accepted change fires a
// single-cycle press or release strobe.
// Ports:
//   clk           - system clock (only clock)
//   reset         - synchronous, active-low reset
//   clk_slow      - asynchronous 500 Hz sample-rate square wave
//   btn_in        - raw bouncing button level, asynchronous
//   btn_level     - debounced button level (registered)
//   press_pulse   - one-cycle strobe on confirmed press (registered)
//   release_pulse - one-cycle strobe on confirmed release (registered)
//   state_dbg     - current FSM state encoding (registered)
module debounce_oneshot
  import debounce_pkg::*;
#(
  parameter int STABLE_CNT = STABLE_CNT_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clk_slow,
  input  logic       btn_in,
  output logic       btn_level,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic [1:0] state_dbg
);

  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CNT - 1);

  logic slow_s;
  logic btn_s;
  logic strobe;

  logic             slow_dly_q, slow_dly_d;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic             release_q, release_d;

  sync_2ff u_sync_slow (
    .clk   (clk),
    .reset (reset),
    .d     (clk_slow),
    .q     (slow_s)
  );

  sync_2ff u_sync_btn (
    .clk   (clk),
    .reset (reset),
    .d     (btn_in),
    .q     (btn_s)
  );

  // Rising edge of the synchronized slow clock: one strobe per period.
  assign strobe = slow_s & ~slow_dly_q;

  always_comb begin
    slow_dly_d = slow_s;
    state_d    = state_q;
    cnt_d      = cnt_q;
    level_d    = level_q;
    press_d    = 1'b0;
    release_d  = 1'b0;

    if (strobe) begin
      case (state_q)
        IDLE: begin
          if (btn_s) begin
            state_d = PRESS_WAIT;
            cnt_d   = CNT_ONE;
          end
        end
        PRESS_WAIT: begin
          if (!btn_s) begin
            state_d = IDLE;
            cnt_d   = CNT_ZERO;
          end else if (cnt_q == CNT_LAST) begin
            state_d = PRESSED;
            cnt_d   = CNT_ZERO;
            level_d = 1'b1;
            press_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        PRESSED: begin
          if (!btn_s) begin
            state_d = RELEASE_WAIT;
            cnt_d   = CNT_ONE;
          end
        end
        RELEASE_WAIT: begin
          // A high sample aborts the release; the level never dropped.
          if (btn_s) begin
            state_d = PRESSED;
            cnt_d   = CNT_ZERO;
          end else if (cnt_q == CNT_LAST) begin
            state_d   = IDLE;
            cnt_d     = CNT_ZERO;
            level_d   = 1'b0;
            release_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = CNT_ZERO;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      slow_dly_q <= 1'b0;
      state_q    <= IDLE;
      cnt_q      <= CNT_ZERO;
      level_q    <= 1'b0;
      press_q    <= 1'b0;
      release_q  <= 1'b0;
    end else begin
      slow_dly_q <= slow_dly_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      level_q    <= level_d;
      press_q    <= press_d;
      release_q  <= release_d;
    end
  end

  assign btn_level     = level_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign state_dbg     = state_q;

endmodule
